ret_addr_stack: RTL and testbench
=================================

// Module: ret_addr_stack
// PURPOSE
//  - Hardware LIFO of return addresses that feeds ret_addr of the program counter.
//  - On call: pushes instr_addr + 1, the address after the calling instruction.
//  - On ret: pops, so the PC loads the top entry at the same clock edge.
//  - Sits beside the PC; the decoder drives the same call/ret strobes to both blocks.
// PARAMETERS
//  INSTR_ADDR_SIZE  5  width of instruction addresses (must match the PC)
//  STACK_DEPTH      8  number of entries, >= 2
//  CNT_W            $clog2(STACK_DEPTH+1)  localparam, width of depth
// PORTS
//  clk        in   1                clock, rising edge
//  rst        in   1                asynchronous, active-low reset
//  call       in   1                push request (same strobe as the PC jmp on a call)
//  ret        in   1                pop request (same strobe as the PC ret)
//  clr_err    in   1                synchronous clear of the sticky error flags
//  instr_addr in   INSTR_ADDR_SIZE  current PC value
//  ret_addr   out  INSTR_ADDR_SIZE  top-of-stack entry, 0 when empty
//  depth      out  CNT_W            number of valid entries
//  empty      out  1                depth == 0
//  full       out  1                depth == STACK_DEPTH
//  overflow   out  1                sticky: call was attempted while full
//  underflow  out  1                sticky: ret was attempted while empty
// BEHAVIOUR
//  - Reset (rst==0, asynchronous):
//    - depth=0, overflow=0, underflow=0, all entries=0.
//    - Therefore ret_addr=0, empty=1, full=0.
//  - Combinational outputs:
//    - ret_addr = entry[depth-1] when depth>0, else 0.
//    - empty and full decode depth only.
//  - All state updates happen on the rising clk edge when rst==1.
//  - Push (call==1):
//    - If not full: entry[depth] <= instr_addr + 1, truncated to INSTR_ADDR_SIZE
//      (so all-ones wraps to 0); depth <= depth + 1.
//    - If full: no write, depth unchanged, overflow <= 1.
//  - Pop (ret==1 and call==0):
//    - If not empty: depth <= depth - 1. The entry is not cleared.
//    - If empty: depth unchanged, underflow <= 1.
//  - Pop timing and latency:
//    - ret_addr is valid before the popping edge, so the PC and the stack use
//      the same edge. Zero-cycle latency for ret.
//    - After that edge, ret_addr shows the next-older entry.
//  - Simultaneous call and ret:
//    - call wins and ret is ignored, matching the PC, where jmp has priority over ret.
//  - clr_err==1:
//    - overflow <= 0 and underflow <= 0, unless the same cycle sets them again;
//      setting wins.
//    - clr_err does not change depth or the entries.
//  - No internal FSM. State is the depth counter, the entry array and the two flags.
//  - depth never exceeds STACK_DEPTH and never goes below 0.
// TESTING
//  1. rst low mid-run with depth=3 -> immediately depth=0, empty=1, ret_addr=0,
//     flags=0, with no clock edge.
//  2. instr_addr=4, call; then instr_addr=10, call -> depth=2, ret_addr=11;
//     ret -> ret_addr=5; ret -> empty=1, ret_addr=0.
//  3. Eight calls with instr_addr=0..7 -> full=1;
//     9th call -> overflow=1, depth=8, ret_addr=8.
//  4. ret while empty -> underflow=1, depth=0;
//     clr_err -> underflow=0 on the next edge.
//  5. call and ret together at depth=1, instr_addr=20 -> depth=2, ret_addr=21.
//  6. call with instr_addr=31 (5-bit) -> pushed value 0, ret_addr=0, empty=0.

Source files
------------

// File: rtl/ret_addr_stack.sv
// Return-address LIFO beside the program counter: call pushes instr_addr+1,
// ret pops with zero latency because ret_addr always shows the current top entry.
module ret_addr_stack #(
    parameter int INSTR_ADDR_SIZE = 5,
    parameter int STACK_DEPTH     = 8,
    localparam int CNT_W          = $clog2(STACK_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       clr_err,
    input  logic [INSTR_ADDR_SIZE-1:0] instr_addr,
    output logic [INSTR_ADDR_SIZE-1:0] ret_addr,
    output logic [CNT_W-1:0]           depth,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [INSTR_ADDR_SIZE-1:0] entry_r [STACK_DEPTH];
    logic [CNT_W-1:0]           depth_r;
    logic                       overflow_r;
    logic                       underflow_r;

    logic                       empty_s;
    logic                       full_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       ovf_set_s;
    logic                       unf_set_s;
    logic [IDX_W-1:0]           wr_idx_s;
    logic [IDX_W-1:0]           top_idx_s;

    assign empty_s = (depth_r == CNT_W'(0));
    assign full_s  = (depth_r == CNT_W'(STACK_DEPTH));

    // Request decode: call has priority over ret, matching the PC's jmp-over-ret rule.
    always_comb begin
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (call) begin
            push_s    = ~full_s;
            ovf_set_s = full_s;
        end else if (ret) begin
            pop_s     = ~empty_s;
            unf_set_s = empty_s;
        end else begin
            push_s = 1'b0;
        end
    end

    // Index decode; both indices are only used when they are in range.
    always_comb begin
        wr_idx_s  = IDX_W'(depth_r);
        top_idx_s = IDX_W'(depth_r - CNT_W'(1));
    end

    // Top-of-stack view, zero when the stack holds nothing.
    always_comb begin
        ret_addr = {INSTR_ADDR_SIZE{1'b0}};
        if (!empty_s) begin
            ret_addr = entry_r[top_idx_s];
        end else begin
            ret_addr = {INSTR_ADDR_SIZE{1'b0}};
        end
    end

    // Entry storage; popped entries are left in place and simply overwritten later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                entry_r[i] <= {INSTR_ADDR_SIZE{1'b0}};
            end
        end else if (push_s) begin
            entry_r[wr_idx_s] <= instr_addr + INSTR_ADDR_SIZE'(1);
        end else begin
            entry_r <= entry_r;
        end
    end

    // Depth counter, saturating at both ends through the push/pop qualifiers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_r <= CNT_W'(0);
        end else if (push_s) begin
            depth_r <= depth_r + CNT_W'(1);
        end else if (pop_s) begin
            depth_r <= depth_r - CNT_W'(1);
        end else begin
            depth_r <= depth_r;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= ovf_set_s | (overflow_r & ~clr_err);
            underflow_r <= unf_set_s | (underflow_r & ~clr_err);
        end
    end

    assign depth     = depth_r;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack: reset, push/pop order, overflow,
// underflow with clear, call/ret collision and address wrap.
module tb_ret_addr_stack;

    localparam int AW    = 5;
    localparam int SD    = 8;
    localparam int CW    = $clog2(SD + 1);

    logic          clk;
    logic          rst;
    logic          call;
    logic          ret;
    logic          clr_err;
    logic [AW-1:0] instr_addr;
    logic [AW-1:0] ret_addr;
    logic [CW-1:0] depth;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int n_checks;
    int n_fail;

    ret_addr_stack #(.INSTR_ADDR_SIZE(AW), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .call(call), .ret(ret), .clr_err(clr_err),
        .instr_addr(instr_addr), .ret_addr(ret_addr), .depth(depth),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        call = 1'b0; ret = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        step();
    endtask

    task automatic push(input logic [AW-1:0] a);
        call = 1'b1; ret = 1'b0; instr_addr = a;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        instr_addr = 5'd0;
        rst = 1'b0;
        #2;
        n_checks++;
        if (depth !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || ret_addr !== 5'd0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: depth=%0d empty=%0b full=%0b ret_addr=%0d ovf=%0b unf=%0b, want 0 1 0 0 0 0",
                     depth, empty, full, ret_addr, overflow, underflow);
        end
        rst = 1'b1;
        step();
        push(5'd1); push(5'd2); push(5'd3);
        n_checks++;
        if (depth !== 4'd3 || ret_addr !== 5'd4) begin
            n_fail++;
            $display("FAIL reset_pre: depth=%0d ret_addr=%0d, want 3 4", depth, ret_addr);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (depth !== 4'd0 || empty !== 1'b1 || ret_addr !== 5'd0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: depth=%0d empty=%0b ret_addr=%0d ovf=%0b unf=%0b, want 0 1 0 0 0",
                     depth, empty, ret_addr, overflow, underflow);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_push_pop();
        do_reset();
        push(5'd4);
        push(5'd10);
        n_checks++;
        if (depth !== 4'd2 || ret_addr !== 5'd11) begin
            n_fail++;
            $display("FAIL push_two: depth=%0d ret_addr=%0d, want 2 11", depth, ret_addr);
        end
        ret = 1'b1;
        #1;
        n_checks++;
        if (ret_addr !== 5'd11) begin
            n_fail++;
            $display("FAIL pop_zero_latency: ret_addr=%0d, want 11", ret_addr);
        end
        step();
        n_checks++;
        if (ret_addr !== 5'd5 || depth !== 4'd1) begin
            n_fail++;
            $display("FAIL pop_one: ret_addr=%0d depth=%0d, want 5 1", ret_addr, depth);
        end
        step();
        idle();
        n_checks++;
        if (empty !== 1'b1 || ret_addr !== 5'd0 || depth !== 4'd0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_two: empty=%0b ret_addr=%0d depth=%0d unf=%0b, want 1 0 0 0",
                     empty, ret_addr, depth, underflow);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < SD; i++) begin
            push(AW'(i));
        end
        n_checks++;
        if (full !== 1'b1 || depth !== 4'd8 || ret_addr !== 5'd8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill: full=%0b depth=%0d ret_addr=%0d ovf=%0b, want 1 8 8 0",
                     full, depth, ret_addr, overflow);
        end
        push(5'd20);
        n_checks++;
        if (overflow !== 1'b1 || depth !== 4'd8 || ret_addr !== 5'd8 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: ovf=%0b depth=%0d ret_addr=%0d full=%0b, want 1 8 8 1",
                     overflow, depth, ret_addr, full);
        end
        ret = 1'b1;
        step();
        idle();
        n_checks++;
        if (ret_addr !== 5'd7 || depth !== 4'd7 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_after_full: ret_addr=%0d depth=%0d ovf=%0b, want 7 7 1",
                     ret_addr, depth, overflow);
        end
    endtask

    task automatic test_underflow_clear();
        do_reset();
        ret = 1'b1;
        step();
        n_checks++;
        if (underflow !== 1'b1 || depth !== 4'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: unf=%0b depth=%0d empty=%0b, want 1 0 1", underflow, depth, empty);
        end
        clr_err = 1'b1;
        step();
        n_checks++;
        if (underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_set_wins: unf=%0b, want 1", underflow);
        end
        ret = 1'b0;
        step();
        idle();
        n_checks++;
        if (underflow !== 1'b0 || depth !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_underflow: unf=%0b depth=%0d, want 0 0", underflow, depth);
        end
    endtask

    task automatic test_call_ret_together();
        do_reset();
        push(5'd2);
        call = 1'b1; ret = 1'b1; instr_addr = 5'd20;
        step();
        idle();
        n_checks++;
        if (depth !== 4'd2 || ret_addr !== 5'd21 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL call_ret_same_cycle: depth=%0d ret_addr=%0d unf=%0b, want 2 21 0",
                     depth, ret_addr, underflow);
        end
        ret = 1'b1;
        step();
        idle();
        n_checks++;
        if (ret_addr !== 5'd3 || depth !== 4'd1) begin
            n_fail++;
            $display("FAIL call_ret_older: ret_addr=%0d depth=%0d, want 3 1", ret_addr, depth);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        push(5'd31);
        n_checks++;
        if (ret_addr !== 5'd0 || empty !== 1'b0 || depth !== 4'd1) begin
            n_fail++;
            $display("FAIL addr_wrap: ret_addr=%0d empty=%0b depth=%0d, want 0 0 1", ret_addr, empty, depth);
        end
        push(5'd30);
        n_checks++;
        if (ret_addr !== 5'd31 || depth !== 4'd2) begin
            n_fail++;
            $display("FAIL addr_high: ret_addr=%0d depth=%0d, want 31 2", ret_addr, depth);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        idle();
        instr_addr = 5'd0;
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_underflow_clear();
        test_call_ret_together();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
